// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared parking state codes, default rate and saturation limits
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'b000,
    ST_WAIT_STAMP = 3'b001,
    ST_CALC       = 3'b010,
    ST_WAIT_PAY   = 3'b011,
    ST_OPEN       = 3'b100,
    ST_ALARM      = 3'b101
  } gate_state_t;

  localparam int          DEFAULT_RATE = 5;
  localparam logic [15:0] SAT16        = 16'hFFFF;
  localparam logic [16:0] SAT17        = 17'h1FFFF;

endpackage

// File: rtl/parking_fee_calc.sv
// rtl/parking_fee_calc.sv - combinational fee = max(hours,1)*RATE saturated to 16 bits
module parking_fee_calc
  import parking_pkg::*;
#(
  parameter int RATE = DEFAULT_RATE
) (
  input  logic [15:0] i_hours,
  output logic [15:0] o_fee
);

  logic [15:0] w_billable;
  logic [31:0] w_product;

  // Any stay shorter than one billed hour is charged as one hour.
  assign w_billable = (i_hours == 16'd0) ? 16'd1 : i_hours;
  assign w_product  = {16'd0, w_billable} * 32'(RATE);
  assign o_fee      = (w_product > {16'd0, SAT16}) ? SAT16 : w_product[15:0];

endmodule

// File: rtl/parking_exit_gate.sv
// rtl/parking_exit_gate.sv - exit barrier controller: ticket stamp, fee, payment, gate and lamps
module parking_exit_gate
  import parking_pkg::*;
#(
  parameter int RATE          = DEFAULT_RATE,
  parameter int STAMP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_hour,
  input  logic        sensor_exit,
  input  logic        stamp_valid,
  input  logic [15:0] stamp_hour,
  input  logic        pay_valid,
  input  logic [15:0] pay_amount,
  input  logic        sensor_clear,
  output logic        GREEN_LED,
  output logic        RED_LED,
  output logic        gate_open,
  output logic [15:0] fee,
  output logic        fee_valid,
  output logic [15:0] change,
  output logic        exit_pulse,
  output logic [2:0]  indicator
);

  gate_state_t r_state, w_next;

  logic [15:0] r_hour, r_stamp, r_tmo, r_fee, r_change;
  logic [16:0] r_paid;
  logic        r_fee_valid, r_gate, r_green, r_red, r_exit_pulse;

  logic [15:0] w_hours, w_fee_calc, w_change_next;
  logic [17:0] w_pay_sum;
  logic [16:0] w_paid_next, w_excess;
  logic        w_pay_en, w_paid_ok, w_tmo_hit, w_start;

  assign w_hours = r_hour - r_stamp;

  parking_fee_calc #(.RATE(RATE)) u_fee_calc (
    .i_hours (w_hours),
    .o_fee   (w_fee_calc)
  );

  assign w_start     = (r_state == ST_IDLE) && sensor_exit;
  assign w_pay_en    = (r_state == ST_WAIT_PAY) && pay_valid;
  assign w_pay_sum   = {1'b0, r_paid} + {2'b00, pay_amount};
  assign w_paid_next = !w_pay_en ? r_paid :
                       (w_pay_sum > {1'b0, SAT17}) ? SAT17 : w_pay_sum[16:0];
  assign w_paid_ok   = r_paid >= {1'b0, r_fee};
  assign w_excess    = w_paid_next - {1'b0, r_fee};
  assign w_change_next = (w_excess > {1'b0, SAT16}) ? SAT16 : w_excess[15:0];
  assign w_tmo_hit   = r_tmo >= 16'(STAMP_TIMEOUT - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       if (sensor_exit) w_next = ST_WAIT_STAMP;
      ST_WAIT_STAMP: begin
        if (stamp_valid)       w_next = ST_CALC;
        else if (!sensor_exit) w_next = ST_IDLE;
        else if (w_tmo_hit)    w_next = ST_ALARM;
      end
      ST_CALC:       w_next = ST_WAIT_PAY;
      ST_WAIT_PAY:   if (w_paid_ok) w_next = ST_OPEN;
      ST_OPEN:       if (sensor_clear) w_next = ST_IDLE;
      ST_ALARM:      if (!sensor_exit) w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hour  <= 16'd0;
      r_stamp <= 16'd0;
      r_tmo   <= 16'd0;
      r_fee   <= 16'd0;
      r_paid  <= 17'd0;
      r_change <= 16'd0;
    end else begin
      if (tick_hour) r_hour <= r_hour + 16'd1;
      if (w_start) begin
        r_tmo    <= 16'd0;
        r_fee    <= 16'd0;
        r_paid   <= 17'd0;
        r_change <= 16'd0;
      end else begin
        if (r_state == ST_WAIT_STAMP) r_tmo <= r_tmo + 16'd1;
        if (r_state == ST_WAIT_STAMP && stamp_valid) r_stamp <= stamp_hour;
        if (r_state == ST_CALC) r_fee <= w_fee_calc;
        r_paid <= w_paid_next;
        // A payment landing on the OPEN-decision cycle still counts toward change.
        if (r_state == ST_WAIT_PAY && w_paid_next >= {1'b0, r_fee})
          r_change <= w_change_next;
      end
    end
  end

  // Lamp/gate registers decode the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fee_valid  <= 1'b0;
      r_gate       <= 1'b0;
      r_green      <= 1'b0;
      r_red        <= 1'b1;
      r_exit_pulse <= 1'b0;
    end else begin
      r_fee_valid  <= (w_next == ST_WAIT_PAY) || (w_next == ST_OPEN);
      r_gate       <= (w_next == ST_OPEN);
      r_green      <= (w_next == ST_OPEN);
      r_red        <= (w_next == ST_ALARM) ? ~r_red : (w_next != ST_OPEN);
      r_exit_pulse <= (r_state == ST_OPEN) && sensor_clear;
    end
  end

  assign GREEN_LED  = r_green;
  assign RED_LED    = r_red;
  assign gate_open  = r_gate;
  assign fee        = r_fee;
  assign fee_valid  = r_fee_valid;
  assign change     = r_change;
  assign exit_pulse = r_exit_pulse;
  assign indicator  = r_state;

endmodule

// File: doc/parking_exit_gate.md
PARKING_EXIT_GATE -- requirements
Module: parking_exit_gate

Interface
REQ-001 Parameters SHALL be:
  - RATE, default 5, fee units per billable hour.
  - STAMP_TIMEOUT, default 255, cycles allowed in WAIT_STAMP before ALARM.
REQ-002 Ports SHALL be:
  - clk  in  1  the only clock; all state on its rising edge.
  - reset_n  in  1  asynchronous, active-low reset.
  - tick_hour  in  1  one-cycle pulse advancing the internal hour clock.
  - sensor_exit  in  1  car present at exit loop.
  - stamp_valid  in  1  one-cycle strobe qualifying stamp_hour.
  - stamp_hour  in  16  entry hour read from ticket.
  - pay_valid  in  1  one-cycle strobe qualifying pay_amount.
  - pay_amount  in  16  payment increment.
  - sensor_clear  in  1  car has passed the barrier.
  - GREEN_LED  out  1  proceed lamp.
  - RED_LED  out  1  stop/alarm lamp.
  - gate_open  out  1  barrier raise command.
  - fee  out  16  computed fee.
  - fee_valid  out  1  fee is meaningful.
  - change  out  16  overpayment returned.
  - exit_pulse  out  1  one-cycle pulse to decrement the lot occupancy count.
  - indicator  out  3  current state code.

Function
REQ-003 A 16-bit hour counter SHALL increment, modulo 2^16, on every cycle with tick_hour=1.
REQ-004 The FSM SHALL have states IDLE(000), WAIT_STAMP(001), CALC(010), WAIT_PAY(011), OPEN(100), ALARM(101); indicator SHALL equal the registered state code.
REQ-005 IDLE: sensor_exit=1 SHALL transition to WAIT_STAMP; clear the timeout counter, paid accumulator, fee, change and fee_valid.
REQ-006 WAIT_STAMP exits, in priority order:
  - stamp_valid=1: capture stamp_hour, go to CALC.
  - else sensor_exit=0: go to IDLE.
  - else timeout counter reaches STAMP_TIMEOUT: go to ALARM.
REQ-007 CALC SHALL last exactly one cycle, then go to WAIT_PAY:
  - hours = (hour counter value before any same-cycle tick) - stamp, modulo 2^16.
  - billable = max(hours, 1).
  - fee = billable*RATE, computed at 32 bits and saturated to 16'hFFFF.
REQ-008 fee_valid SHALL be 1 in WAIT_PAY and OPEN and 0 elsewhere; fee SHALL hold until the next IDLE→WAIT_STAMP transition.
REQ-009 WAIT_PAY payment handling:
  - Each pay_valid adds pay_amount into a 17-bit accumulator saturating at 17'h1FFFF.
  - When the accumulator ≥ fee (including fee=0), go to OPEN on the next cycle.
  - change = min(accumulator - fee, 16'hFFFF).
REQ-010 pay_valid outside WAIT_PAY SHALL be ignored; a pay_valid in the same cycle as the WAIT_PAY→OPEN decision SHALL still be accumulated into change.
REQ-011 sensor_exit=0 during WAIT_PAY SHALL NOT abort the transaction.
REQ-012 OPEN: gate_open=1; sensor_clear=1 SHALL return to IDLE and assert exit_pulse for exactly that one transition cycle.
REQ-013 ALARM: RED_LED SHALL toggle every cycle; sensor_exit=0 SHALL return to IDLE.
REQ-014 Lamps per state:
  - IDLE: GREEN_LED=0, RED_LED=1.
  - WAIT_STAMP, CALC, WAIT_PAY: GREEN_LED=0, RED_LED=1.
  - OPEN: GREEN_LED=1, RED_LED=0.
REQ-015 All outputs SHALL be registered Moore outputs, valid one cycle after state entry.
REQ-016 stamp_hour later than the hour counter SHALL be billed via modular wrap (no special case).

Reset
REQ-017 reset_n=0 SHALL asynchronously force:
  - state IDLE, hour counter 0, accumulator 0, timeout counter 0.
  - fee 0, change 0, fee_valid 0.
  - gate_open 0, exit_pulse 0.
  - GREEN_LED 0, RED_LED 1, indicator 000.
REQ-018 Reset asserted in OPEN SHALL drop gate_open immediately (asynchronously), with no exit_pulse.

Structure
REQ-019 A shared package parking_pkg SHALL hold the state encodings/indicator codes, the default RATE and the 16-bit saturation constant, shared with the entrance controller.
REQ-020 The multiply-and-saturate of REQ-007 SHALL be a sub-module parking_fee_calc, combinational, instantiated once and registered in CALC.

Verification
REQ-021 Normal exit: hour counter=10, stamp=7, RATE=5, pay 10 then 5 → fee=15, OPEN after the second payment, change=0, exit_pulse once on sensor_clear.
REQ-022 Minimum charge and overpay: stamp equals the hour counter, pay 20 → fee=5, change=15, gate_open=1.
REQ-023 Wrap-around: hour counter=2, stamp=16'hFFFE → hours=4, fee=20.
REQ-024 Timeout: sensor_exit held, no stamp for 255 cycles → ALARM, indicator=101, RED_LED toggling; release sensor_exit → IDLE.
REQ-025 Saturation and abort: stamp gives hours=20000 → fee=16'hFFFF. Separately, sensor_exit dropping in WAIT_STAMP → IDLE with fee_valid=0.
REQ-026 Reset mid-OPEN: reset_n=0 → gate_open=0 within the same cycle, indicator=000, exit_pulse never asserted.
